// File: rtl/full_adder.sv
// Single-bit full adder: combinational leaf cell plus a clocked path that
// registers results, can chain its own carry for LSB-first serial addition,
// counts applied vectors and records which input combinations were seen.
module full_adder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             valid,
  input  logic             serial_en,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [7:0]       cov_map,
  output logic             cov_full
);

  // Majority of three bits: the carry function of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    maj3 = (x & y) | (x & z) | (y & z);
  endfunction

  // Parity of three bits: the sum function of a full adder.
  function automatic logic par3(input logic x, input logic y, input logic z);
    par3 = x ^ y ^ z;
  endfunction

  logic             ci_s;
  logic [2:0]       combo_s;
  logic             sum_nxt_s;
  logic             cout_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [7:0]       cov_nxt_s;

  // Leaf arithmetic: depends only on a, b, cin; no clock, no state.
  always_comb begin
    sum  = par3(a, b, cin);
    cout = maj3(a, b, cin);
  end

  // Next-state for the clocked path; hold everything when not valid.
  always_comb begin
    ci_s       = serial_en ? cout_q : cin;
    combo_s    = {a, b, cin};
    sum_nxt_s  = sum_q;
    cout_nxt_s = cout_q;
    cnt_nxt_s  = vec_cnt;
    cov_nxt_s  = cov_map;
    if (valid) begin
      sum_nxt_s  = par3(a, b, ci_s);
      cout_nxt_s = maj3(a, b, ci_s);
      // Coverage tracks the raw cin, not the chained carry.
      cov_nxt_s  = cov_map | (8'b0000_0001 << combo_s);
      if (vec_cnt == {CNT_W{1'b1}}) begin
        cnt_nxt_s = vec_cnt;
      end else begin
        cnt_nxt_s = vec_cnt + CNT_W'(1);
      end
    end else begin
      sum_nxt_s  = sum_q;
      cout_nxt_s = cout_q;
      cnt_nxt_s  = vec_cnt;
      cov_nxt_s  = cov_map;
    end
  end

  // Result, carry, counter and coverage registers; reset wins over valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      vec_cnt <= {CNT_W{1'b0}};
      cov_map <= 8'h00;
    end else begin
      sum_q   <= sum_nxt_s;
      cout_q  <= cout_nxt_s;
      valid_q <= valid;
      vec_cnt <= cnt_nxt_s;
      cov_map <= cov_nxt_s;
    end
  end

  // All eight combinations seen.
  always_comb begin
    cov_full = &cov_map;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed, table-driven bench for full_adder: exhaustive combinational
// truth table, registered path, serial addition, coverage, hold,
// saturation (second instance with a 2-bit counter) and reset corner cases.
module tb_full_adder;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst, a, b, cin, valid, serial_en;
  logic        sum, cout, sum_q, cout_q, valid_q;
  logic [15:0] vec_cnt;
  logic [7:0]  cov_map;
  logic        cov_full;
  logic        sum2, cout2, sum_q2, cout_q2, valid_q2;
  logic [1:0]  vec_cnt2;
  logic [7:0]  cov_map2;
  logic        cov_full2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic c;
  } vec_t;

  vec_t tt[8];
  logic ser_a[4];
  logic ser_b[4];
  logic ser_s[4];
  int   cov_seq[10];

  full_adder #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .valid(valid),
    .serial_en(serial_en), .sum(sum), .cout(cout), .sum_q(sum_q),
    .cout_q(cout_q), .valid_q(valid_q), .vec_cnt(vec_cnt),
    .cov_map(cov_map), .cov_full(cov_full)
  );

  full_adder #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .valid(valid),
    .serial_en(serial_en), .sum(sum2), .cout(cout2), .sum_q(sum_q2),
    .cout_q(cout_q2), .valid_q(valid_q2), .vec_cnt(vec_cnt2),
    .cov_map(cov_map2), .cov_full(cov_full2)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic vb, input logic vc,
                       input logic vv, input logic vs);
    a = va; b = vb; cin = vc; valid = vv; serial_en = vs;
  endtask

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // 0b1011 + 0b0111, LSB first
    ser_a = '{1'b1, 1'b1, 1'b0, 1'b1};
    ser_b = '{1'b1, 1'b1, 1'b1, 1'b0};
    ser_s = '{1'b0, 1'b1, 1'b0, 1'b0};
    cov_seq = '{0, 1, 2, 3, 3, 4, 5, 0, 6, 7};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Combinational truth table with the clock stopped
    for (int i = 0; i < 8; i++) begin
      drive(tt[i].a, tt[i].b, tt[i].cin, 1'b0, 1'b0);
      #1;
      check($sformatf("comb_sum_%0d", i), 32'(sum), 32'(tt[i].s));
      check($sformatf("comb_cout_%0d", i), 32'(cout), 32'(tt[i].c));
    end

    // Reset state
    clk_en = 1'b1;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("rst_sum_q", 32'(sum_q), 32'd0);
    check("rst_cout_q", 32'(cout_q), 32'd0);
    check("rst_valid_q", 32'(valid_q), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    check("rst_cov_map", 32'(cov_map), 32'd0);
    check("rst_cov_full", 32'(cov_full), 32'd0);

    // Single registered vector 1,0,1
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("reg_sum_q", 32'(sum_q), 32'd0);
    check("reg_cout_q", 32'(cout_q), 32'd1);
    check("reg_valid_q", 32'(valid_q), 32'd1);
    check("reg_vec_cnt", 32'(vec_cnt), 32'd1);
    check("reg_cov_map", 32'(cov_map), 32'h20);

    // Serial add 11 + 7 = 18
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(ser_a[i], ser_b[i], 1'b0, 1'b1, (i != 0));
      step();
      check($sformatf("ser_sum_q_%0d", i), 32'(sum_q), 32'(ser_s[i]));
    end
    check("ser_cout_q", 32'(cout_q), 32'd1);
    check("ser_vec_cnt", 32'(vec_cnt), 32'd4);

    // Hold with valid=0 while inputs toggle; serial carry must survive
    for (int i = 0; i < 3; i++) begin
      drive(i[0], ~i[0], i[1], 1'b0, 1'b1);
      step();
      check($sformatf("hold_sum_q_%0d", i), 32'(sum_q), 32'd0);
      check($sformatf("hold_cout_q_%0d", i), 32'(cout_q), 32'd1);
      check($sformatf("hold_vec_cnt_%0d", i), 32'(vec_cnt), 32'd4);
      check($sformatf("hold_valid_q_%0d", i), 32'(valid_q), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("held_carry_sum_q", 32'(sum_q), 32'd1);
    check("held_carry_cout_q", 32'(cout_q), 32'd0);

    // Reset mid-serial with carry set; reset beats valid
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("pre_rst_cout_q", 32'(cout_q), 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    check("rst_comb_sum", 32'(sum), 32'd0);
    check("rst_comb_cout", 32'(cout), 32'd1);
    step();
    check("mid_rst_sum_q", 32'(sum_q), 32'd0);
    check("mid_rst_cout_q", 32'(cout_q), 32'd0);
    check("mid_rst_valid_q", 32'(valid_q), 32'd0);
    check("mid_rst_vec_cnt", 32'(vec_cnt), 32'd0);
    check("mid_rst_cov_map", 32'(cov_map), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check("rst_comb_sum2", 32'(sum), 32'd1);
    check("rst_comb_cout2", 32'(cout), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("post_rst_sum_q", 32'(sum_q), 32'd1);
    check("post_rst_cout_q", 32'(cout_q), 32'd0);

    // Coverage fill plus 2-bit counter saturation
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(tt[cov_seq[i]].a, tt[cov_seq[i]].b, tt[cov_seq[i]].cin, 1'b1, 1'b0);
      if (i == 9) begin
        check("cov_full_before_8th", 32'(cov_full), 32'd0);
        check("cov_map_7_combos", 32'(cov_map), 32'h7F);
      end
      step();
      check($sformatf("cnt2_%0d", i), 32'(vec_cnt2), (i >= 2) ? 32'd3 : 32'(i + 1));
      check($sformatf("sat_sum_q2_%0d", i), 32'(sum_q2), 32'(tt[cov_seq[i]].s));
      check($sformatf("sat_cout_q2_%0d", i), 32'(cout_q2), 32'(tt[cov_seq[i]].c));
    end
    check("cov_full_after_8th", 32'(cov_full), 32'd1);
    check("cov_map_full", 32'(cov_map), 32'hFF);
    check("vec_cnt_10", 32'(vec_cnt), 32'd10);
    valid = 1'b0;
    step();
    check("cov_sticky", 32'(cov_map), 32'hFF);
    rst = 1'b1;
    step();
    check("cov_map_reset", 32'(cov_map), 32'h00);
    check("cov_full_reset", 32'(cov_full), 32'd0);
    check("cnt2_reset", 32'(vec_cnt2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder with a combinational result path plus a clocked path for bit-serial addition and stimulus bookkeeping. The combinational `sum`/`cout` outputs serve as the leaf arithmetic cell for ripple structures and must settle within one simulation time step of any input change, with no clock running. The clocked path registers results, optionally chains its own carry for LSB-first serial addition, and records which of the 8 input combinations have been applied.

## Interface
Parameters:
- `CNT_W`, 16: width of the applied-vector counter.

Ports:
- `clk` input 1: single clock; all registers update on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `a` input 1: addend bit.
- `b` input 1: addend bit.
- `cin` input 1: carry-in bit.
- `valid` input 1: qualifies `a`/`b`/`cin` for the clocked path.
- `serial_en` input 1: when 1, the clocked path uses its registered carry in place of `cin`.
- `sum` output 1: combinational `a ^ b ^ cin`.
- `cout` output 1: combinational majority(`a`, `b`, `cin`).
- `sum_q` output 1: registered sum.
- `cout_q` output 1: registered carry-out; this is also the serial carry state.
- `valid_q` output 1: `valid` delayed by one cycle.
- `vec_cnt` output CNT_W: count of cycles with `valid`=1, saturating.
- `cov_map` output 8: bit `{a,b,cin}` is set once that combination has been applied with `valid`=1.
- `cov_full` output 1: `&cov_map`.

## Operation
- Combinational path:
  - `sum` and `cout` depend only on `a`, `b`, `cin`.
  - They ignore `clk`, `rst`, `valid` and `serial_en`.
  - They contain no state.
- Truth table for (a b cin → sum cout): 000→00, 001→10, 010→10, 011→01, 100→10, 101→01, 110→01, 111→11.
- Effective carry for the clocked path: `ci = serial_en ? cout_q : cin`.
- On a clock edge with `valid`=1:
  - `sum_q <= a^b^ci`.
  - `cout_q <= majority(a,b,ci)`.
  - `vec_cnt` increments, holding at all-ones (no wrap).
  - `cov_map[{a,b,cin}] <= 1`. Coverage always indexes the raw `cin`, even when `serial_en`=1.
- On a clock edge with `valid`=0: `sum_q`, `cout_q`, `vec_cnt` and `cov_map` hold.
- `valid_q <= valid` on every edge.
- Serial use:
  - Present bits LSB first, one per valid cycle.
  - On the first bit, drive `serial_en`=0 and put the initial carry on `cin`.
  - On subsequent bits, drive `serial_en`=1.
  - The final carry-out is `cout_q` after the last bit.

## Timing
- Combinational outputs have zero-cycle latency and are purely combinational.
- Clocked outputs have 1-cycle latency: results of the edge-k inputs appear after edge k.
- Reset (`rst`=1 at an edge):
  - All registered outputs become 0: `sum_q`, `cout_q`, `valid_q`, `vec_cnt`, `cov_map`. As a result `cov_full`=0.
  - Reset takes priority over `valid`.
  - Reset mid-serial-sequence discards the carry.
  - Combinational outputs are unaffected by reset.
- `cov_map` bits are sticky until reset.
- `cov_full` is combinational from `cov_map` and rises in the cycle after the eighth distinct combination is captured.
- `vec_cnt` saturation: at all-ones with `valid`=1, the count stays all-ones while other updates proceed.
- `serial_en`=1 with `valid`=0: no effect and carry is held.

## Test plan
- Exhaustive combinational check: apply all 8 `{a,b,cin}` with no clock, wait 1 ns each, and compare `sum`/`cout` to the truth table. Example: 1,1,1 → 1,1; 0,1,1 → 0,1.
- Registered path: reset, then apply `valid`=1 with 1,0,1 and `serial_en`=0 for one edge → `sum_q`=0, `cout_q`=1, `valid_q`=1, `vec_cnt`=1.
- Serial add of 4-bit 0b1011 + 0b0111 with initial `cin`=0 (bits LSB first, `serial_en`=0 then 1,1,1):
  - Captured `sum_q` sequence is 0,1,0,0.
  - Final `cout_q`=1, giving a total of 18.
- Coverage: apply 7 distinct combos plus repeats → `cov_full`=0. Apply the 8th → `cov_full`=1 one cycle later. Assert `rst` → `cov_map`=0x00.
- Hold and saturation:
  - Toggle inputs with `valid`=0 → `sum_q`/`cout_q`/`vec_cnt` unchanged.
  - With `CNT_W`=2, apply 5 valid cycles → `vec_cnt` stays at 3.
- Reset mid-operation: during a serial sequence with `cout_q`=1, assert `rst` and `valid` together → all registers 0, while combinational outputs keep tracking inputs.
